pwm_servo_generator: RTL and testbench

PWM_SERVO_GENERATOR -- requirements
Module: pwm_servo_generator

---
 rtl/pwm_gen_pkg.sv | 21 ++
 rtl/pwm_servo_generator_if.sv | 23 ++
 rtl/pwm_width_calc.sv | 29 ++
 rtl/pwm_servo_generator.sv | 126 ++++++++++++
 tb/tb_pwm_servo_generator.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_gen_pkg.sv
// Shared state encoding and default timing constants for the servo PWM generator.
package pwm_gen_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StHigh = 2'b01,
        StLow  = 2'b10
    } state_e;

    // Default timing: 20 ms frame, 1.0 ms .. 2.0 ms pulse at a 1 MHz clock
    localparam int unsigned DefPeriodCycles = 20000;
    localparam int unsigned DefMinPulse     = 1000;
    localparam int unsigned DefMaxPulse     = 2000;
    localparam int unsigned DefStep         = 4;

    localparam int unsigned SetpointW = 8;
    localparam int unsigned WidthW    = 11;
    localparam int unsigned CalcW     = 12;
    localparam int unsigned CntW      = 15;

endpackage

// File: rtl/pwm_servo_generator_if.sv
// Control/status bundle between a host and the servo PWM generator.
interface pwm_servo_generator_if;
    import pwm_gen_pkg::*;

    logic                 enable;
    logic [SetpointW-1:0] setpoint;
    logic                 load;
    logic                 pwm_out;
    logic                 frame_start;
    logic                 active;
    logic [WidthW-1:0]    width_q;

    modport master (
        output enable, setpoint, load,
        input  pwm_out, frame_start, active, width_q
    );

    modport slave (
        input  enable, setpoint, load,
        output pwm_out, frame_start, active, width_q
    );

endinterface

// File: rtl/pwm_width_calc.sv
// Combinational pulse-width computation: MIN_PULSE + STEP*setpoint, clamped to MAX_PULSE.
module pwm_width_calc
    import pwm_gen_pkg::*;
#(
    parameter int unsigned MIN_PULSE = DefMinPulse,
    parameter int unsigned MAX_PULSE = DefMaxPulse,
    parameter int unsigned STEP      = DefStep
) (
    input  logic [SetpointW-1:0] i_setpoint,
    output logic [WidthW-1:0]    o_width
);

    localparam logic [CalcW-1:0] MinW  = CalcW'(MIN_PULSE);
    localparam logic [CalcW-1:0] MaxW  = CalcW'(MAX_PULSE);
    localparam logic [CalcW-1:0] StepW = CalcW'(STEP);

    logic [CalcW-1:0] w_raw;

    // Unclamped width in 12-bit arithmetic, then saturate at the upper limit
    always_comb begin
        w_raw = MinW + StepW * CalcW'(i_setpoint);
        if (w_raw > MaxW) begin
            o_width = WidthW'(MaxW);
        end else begin
            o_width = WidthW'(w_raw);
        end
    end

endmodule

// File: rtl/pwm_servo_generator.sv
// Servo PWM generator: frame FSM, frame counter, setpoint shadow register and reset synchroniser.
module pwm_servo_generator
    import pwm_gen_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = DefPeriodCycles,
    parameter int unsigned MIN_PULSE     = DefMinPulse,
    parameter int unsigned MAX_PULSE     = DefMaxPulse,
    parameter int unsigned STEP          = DefStep
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pwm_servo_generator_if.slave  bus
);

    localparam logic [CntW-1:0] LastCnt = CntW'(PERIOD_CYCLES - 1);

    logic [1:0]           r_rst_sync;
    state_e               r_state;
    state_e               w_state_d;
    logic [CntW-1:0]      r_cnt;
    logic [CntW-1:0]      w_cnt_d;
    logic [SetpointW-1:0] r_shadow;
    logic [WidthW-1:0]    r_width;
    logic [WidthW-1:0]    w_width_d;
    logic [WidthW-1:0]    w_calc_width;
    logic                 w_start;
    logic                 r_pwm;
    logic                 r_frame_start;
    logic                 r_active;

    pwm_width_calc #(
        .MIN_PULSE (MIN_PULSE),
        .MAX_PULSE (MAX_PULSE),
        .STEP      (STEP)
    ) u_width_calc (
        .i_setpoint (r_shadow),
        .o_width    (w_calc_width)
    );

    // Reset release synchroniser: asserts asynchronously, releases through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Shadow register; loads are ignored until the release has reached the second stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (bus.load && r_rst_sync[1]) begin
            r_shadow <= bus.setpoint;
        end
    end

    // Next-state, counter and width relatch decisions
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_width_d = r_width;
        w_start   = 1'b0;
        unique case (r_state)
            StIdle: begin
                // The FSM may leave IDLE on the same edge the second sync stage releases
                if (bus.enable && r_rst_sync[0]) begin
                    w_start = 1'b1;
                end
            end
            StHigh: begin
                w_cnt_d = r_cnt + CntW'(1);
                if (r_cnt == CntW'(r_width) - CntW'(1)) begin
                    w_state_d = StLow;
                end
            end
            StLow: begin
                if (r_cnt == LastCnt) begin
                    if (bus.enable) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
        // Frame boundary: width comes from the shadow value held before this edge
        if (w_start) begin
            w_state_d = StHigh;
            w_cnt_d   = '0;
            w_width_d = w_calc_width;
        end
    end

    // State, counter, width and registered outputs; reset clears pwm_out immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_width       <= '0;
            r_pwm         <= 1'b0;
            r_frame_start <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_width       <= w_width_d;
            r_pwm         <= (w_state_d == StHigh);
            r_frame_start <= w_start;
            r_active      <= (w_state_d != StIdle);
        end
    end

    assign bus.pwm_out     = r_pwm;
    assign bus.frame_start = r_frame_start;
    assign bus.active      = r_active;
    assign bus.width_q     = r_width;

endmodule

// File: tb/tb_pwm_servo_generator.sv
// Directed bench for pwm_servo_generator: a short-period instance for most scenarios plus a
// default-parameter instance for the full 20000-cycle frame.
module tb_pwm_servo_generator;

    localparam int unsigned TbPeriod = 3000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pwm_servo_generator_if bus ();
    pwm_servo_generator_if bus_d ();

    assign bus_d.enable   = bus.enable;
    assign bus_d.setpoint = bus.setpoint;
    assign bus_d.load     = bus.load;

    pwm_servo_generator #(
        .PERIOD_CYCLES (TbPeriod)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pwm_servo_generator dut_def (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_fs(output logic ok);
        int n;
        n = 0;
        while (bus.frame_start !== 1'b1 && n < 25000) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.frame_start === 1'b1);
    endtask

    // Called on the first cycle of a frame; returns on the first cycle after that frame
    task automatic measure(output int hi, output int per, output logic [10:0] w);
        w   = bus.width_q;
        hi  = 0;
        per = 0;
        do begin
            if (bus.pwm_out === 1'b1) hi++;
            per++;
            @(negedge clk);
        end while (bus.frame_start !== 1'b1 && bus.active === 1'b1 && per < 5000);
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.setpoint = v;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    initial begin
        logic        ok;
        int          hi, per, lo, act, fs, wbad;
        int          hi_d, lo_d, fs_d, hi_m, fs_m;
        logic [10:0] w;

        total = 0;
        bad   = 0;
        rst_n        = 1'b0;
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.setpoint = 8'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_pwm", bus.pwm_out, 0);
        chk("rst_fs", bus.frame_start, 0);
        chk("rst_active", bus.active, 0);
        chk("rst_width", bus.width_q, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("rst_hold_active", bus.active, 0);

        // Release: first frame_start after the second rising edge
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_edge1_fs", bus.frame_start, 0);
        @(negedge clk);
        chk("rel_edge2_fs", bus.frame_start, 1);
        chk("rel_edge2_pwm", bus.pwm_out, 1);
        chk("rel_width0", bus.width_q, 1000);

        // Setpoint 0 over one full default frame (both instances started together)
        hi_d = 0; lo_d = 0; fs_d = 0; hi_m = 0; fs_m = 0;
        for (int n = 0; n <= 20000; n++) begin
            if (n < 20000) begin
                if (bus_d.pwm_out === 1'b1) hi_d++;
                else if (bus_d.active === 1'b1) lo_d++;
            end
            if (n < int'(TbPeriod) && bus.pwm_out === 1'b1) hi_m++;
            if (n > 0 && bus_d.frame_start === 1'b1 && fs_d == 0) fs_d = n;
            if (n > 0 && bus.frame_start === 1'b1 && fs_m == 0) fs_m = n;
            if (n < 20000) @(negedge clk);
        end
        chk("def_high", hi_d, 1000);
        chk("def_low", lo_d, 19000);
        chk("def_fs_spacing", fs_d, 20000);
        chk("def_width", bus_d.width_q, 1000);
        chk("tb_high", hi_m, 1000);
        chk("tb_fs_spacing", fs_m, TbPeriod);

        // Setpoint 250, then 255: both clamp to 2000
        do_load(8'd250);
        wait_fs(ok);
        chk("sp250_found", ok, 1);
        measure(hi, per, w);
        chk("sp250_width", w, 2000);
        chk("sp250_high", hi, 2000);
        chk("sp250_period", per, TbPeriod);
        do_load(8'd255);
        wait_fs(ok);
        chk("sp255_found", ok, 1);
        measure(hi, per, w);
        chk("sp255_width", w, 2000);
        chk("sp255_high", hi, 2000);

        // Mid-frame load of 100 at cycle 500 of a 1000-wide frame
        do_load(8'd0);
        wait_fs(ok);
        chk("mid_found", ok, 1);
        hi = 0; wbad = 0;
        for (int n = 0; n < int'(TbPeriod); n++) begin
            bus.load = (n == 500);
            if (n == 500) bus.setpoint = 8'd100;
            if (bus.pwm_out === 1'b1) hi++;
            if (bus.width_q !== 11'd1000) wbad++;
            @(negedge clk);
        end
        bus.load = 1'b0;
        chk("mid_cur_high", hi, 1000);
        chk("mid_width_stable", wbad, 0);
        chk("mid_next_fs", bus.frame_start, 1);
        measure(hi, per, w);
        chk("mid_next_width", w, 1400);
        chk("mid_next_high", hi, 1400);

        // Enable dropped at cycle 300: frame completes, then idle
        do_load(8'd0);
        wait_fs(ok);
        chk("drop_found", ok, 1);
        hi = 0; act = 0; fs = 0;
        for (int n = 0; n < int'(TbPeriod) + 10; n++) begin
            if (n == 300) bus.enable = 1'b0;
            if (bus.pwm_out === 1'b1) hi++;
            if (bus.active === 1'b1) act++;
            if (n > 0 && bus.frame_start === 1'b1) fs++;
            @(negedge clk);
        end
        chk("drop_high", hi, 1000);
        chk("drop_active_cycles", act, TbPeriod);
        chk("drop_no_fs", fs, 0);
        chk("drop_idle_active", bus.active, 0);
        chk("drop_idle_pwm", bus.pwm_out, 0);

        // Reset asserted at cycle 700 of the pulse clears pwm_out before any clock edge
        bus.enable = 1'b1;
        wait_fs(ok);
        chk("rstmid_found", ok, 1);
        repeat (700) @(negedge clk);
        chk("rstmid_pwm_before", bus.pwm_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_pwm_now", bus.pwm_out, 0);
        chk("rstmid_active_now", bus.active, 0);
        chk("rstmid_width_now", bus.width_q, 0);
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstmid_state", dut.r_state, 0);
        chk("rstmid_active_after", bus.active, 0);
        chk("rstmid_width_after", bus.width_q, 0);

        // Load of 50 on the frame-boundary edge applies one frame later
        bus.enable = 1'b1;
        wait_fs(ok);
        chk("bnd_found", ok, 1);
        chk("bnd_width_a", bus.width_q, 1000);
        repeat (TbPeriod - 1) @(negedge clk);
        bus.setpoint = 8'd50;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
        chk("bnd_fs", bus.frame_start, 1);
        measure(hi, per, w);
        chk("bnd_width_b", w, 1000);
        chk("bnd_high_b", hi, 1000);
        chk("bnd_fs_c", bus.frame_start, 1);
        measure(hi, per, w);
        chk("bnd_width_c", w, 1200);
        chk("bnd_high_c", hi, 1200);
        bus.enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
